can_crc_unit: RTL and testbench
===============================

Name: can_crc_unit

Overview:
- Parametrised CAN/CAN FD CRC generator and checker.
- Computes CRC-15 (classic CAN), CRC-17 and CRC-21 (CAN FD) in parallel on every sampled bit.
- Exposes the selected CRC to the transmitter and compares it against the received CRC field, then flags the result.
- Sits between the bit-timing unit (source of samplePoint) and the error-management block.

Parameters:
- POLY15, 15'h4599, CRC-15 polynomial without the x^15 term
- POLY17, 17'h1685B, CRC-17 polynomial without the x^17 term
- POLY21, 21'h102899, CRC-21 polynomial without the x^21 term
- INIT15, 15'h0000, CRC-15 start value
- INIT17, 17'h10000, CRC-17 start value
- INIT21, 21'h100000, CRC-21 start value

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- samplePoint  input  1  one-clk strobe; the bus bit is valid on canRX
- canRX  input  1  sampled bus bit
- isStuff  input  1  current sampled bit is a stuff bit (dynamic or fixed)
- crcStart  input  1  one-clk pulse; loads INIT values, latches crcSel, clears check state
- crcCalc_on  input  1  accumulate phase enable (SOF through end of data field)
- crcCheck  input  1  receive-CRC-field phase enable
- crcSel  input  2  0 none, 1 CRC-15, 2 CRC-17, 3 CRC-21; sampled only on crcStart
- crcResult  output  21  selected CRC, zero-extended
- crcBitOut  output  1  MSB of the selected CRC register, for the transmit path
- crcDone  output  1  received CRC field complete
- crcError  output  1  received CRC != computed CRC; qualified by crcDone

Behaviour:
- Reset (reset_n low, async):
  - all CRC registers 0, selReg 0, rxCrc 0, bitCnt 0
  - crcResult 0, crcBitOut 0, crcDone 0, crcError 0
- crcStart:
  - next clk edge: crc15/17/21 <= INIT*, selReg <= crcSel, rxCrc 0, bitCnt 0, crcDone 0, crcError 0.
  - Has priority over a coincident samplePoint; that bit is discarded.
- Accumulate phase:
  - Active on samplePoint & crcCalc_on & ~crcCheck.
  - Per register of width N: nxt = canRX ^ crc[N-1]; crc <= {crc[N-2:0],1'b0} ^ (nxt ? POLY : 0).
  - Stuff-bit rule:
    - CRC-15 skips the update when isStuff=1.
    - CRC-17 and CRC-21 include stuff bits (ISO 11898-1:2015).
  - All three registers always update (subject to the stuff-bit rule), independent of selReg.
- Outputs:
  - crcResult and crcBitOut are registered views, valid one clk after the samplePoint edge that changed them.
  - crcResult/crcBitOut = selected register; 0 when selReg=0.
- Check phase:
  - Active on samplePoint & crcCheck & ~isStuff.
  - Effect: rxCrc <= {rxCrc[19:0], canRX}; bitCnt++.
  - Computed registers are frozen (crcCheck has priority over crcCalc_on).
  - Stuff bits are never shifted into rxCrc.
- Completion:
  - Triggered when bitCnt reaches W (15/17/21 per selReg) on a check-phase sample.
  - Next clk: crcDone=1 and crcError = (rxCrc[W-1:0] != selected CRC).
  - crcDone and crcError hold until crcStart or reset.
  - Further check samples after crcDone are ignored: no shift, bitCnt saturates.
- selReg=0: no CRC is tracked; crcDone never asserts; crcError stays 0.
- samplePoint without crcCalc_on/crcCheck: no state change.
- Reset mid-frame: immediate return to reset values; the next frame requires crcStart.
- bitCnt width: 5 bits.

Test Plan:
- Single bit into CRC-15: crcStart with crcSel=1, one sample canRX=1 -> crcResult=0x4599, crcBitOut=1 one clk later.
- CRC-17 from INIT17: crcSel=2, sample canRX=1 -> crcResult=0x00000; after crcStart, sample canRX=0 -> crcResult=0x1685B.
- Stuff-bit handling:
  - crcSel=1, canRX=1 with isStuff=1 -> crcResult stays 0x0000.
  - crcSel=3, canRX=0 with isStuff=1 -> crcResult=0x102899.
- Check pass/fail:
  - Setup: crcSel=1, accumulate bit 1 (CRC 0x4599), then crcCheck.
  - Shift 100010110011001 MSB-first, with a stuff-flagged bit inserted mid-field -> crcDone=1, crcError=0.
  - Repeat with the last bit flipped -> crcDone=1, crcError=1.
- Priority: crcStart coincident with samplePoint canRX=1, crcSel=1 -> crcResult=0x0000. crcCalc_on and crcCheck both high -> calc registers unchanged, bitCnt increments.
- Async reset: assert reset_n low mid check phase with no clk edge -> crcDone, crcError, crcResult read 0 immediately. Release, then samplePoint with crcCheck -> crcDone stays 0 (selReg=0).

Source files
------------

// File: rtl/can_crc_unit.sv
// CAN / CAN FD CRC generator and checker: CRC-15, CRC-17 and CRC-21 run side by side,
// the one picked at crcStart drives the transmit path and is compared with the received field.
module can_crc_unit #(
    parameter logic [14:0] POLY15 = 15'h4599,
    parameter logic [16:0] POLY17 = 17'h1685B,
    parameter logic [20:0] POLY21 = 21'h102899,
    parameter logic [14:0] INIT15 = 15'h0000,
    parameter logic [16:0] INIT17 = 17'h10000,
    parameter logic [20:0] INIT21 = 21'h100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        samplePoint,
    input  logic        canRX,
    input  logic        isStuff,
    input  logic        crcStart,
    input  logic        crcCalc_on,
    input  logic        crcCheck,
    input  logic [1:0]  crcSel,
    output logic [20:0] crcResult,
    output logic        crcBitOut,
    output logic        crcDone,
    output logic        crcError
);

    logic [14:0] crc15, n15;
    logic [16:0] crc17, n17;
    logic [20:0] crc21, n21;
    logic [1:0]  selReg, nsel;
    logic [20:0] rxCrc, nrx;
    logic [4:0]  bitCnt, ncnt;
    logic        ndone, nerr;
    logic [20:0] nres;
    logic        nbit;
    logic [4:0]  width;
    logic [20:0] mask;
    logic [20:0] sel_crc;
    logic        calc_en, chk_en;

    assign calc_en = samplePoint & crcCalc_on & ~crcCheck;
    // Samples after completion are dropped so the verdict cannot be disturbed.
    assign chk_en  = samplePoint & crcCheck & ~isStuff & ~crcDone;

    always_comb begin
        width   = 5'd0;
        mask    = 21'h0;
        sel_crc = 21'h0;
        case (selReg)
            2'd1: begin width = 5'd15; mask = 21'h007FFF; sel_crc = {6'd0, crc15}; end
            2'd2: begin width = 5'd17; mask = 21'h01FFFF; sel_crc = {4'd0, crc17}; end
            2'd3: begin width = 5'd21; mask = 21'h1FFFFF; sel_crc = crc21;         end
            default: ;
        endcase
    end

    always_comb begin
        n15   = crc15;
        n17   = crc17;
        n21   = crc21;
        nsel  = selReg;
        nrx   = rxCrc;
        ncnt  = bitCnt;
        ndone = crcDone;
        nerr  = crcError;
        if (crcStart) begin
            n15   = INIT15;
            n17   = INIT17;
            n21   = INIT21;
            nsel  = crcSel;
            nrx   = 21'h0;
            ncnt  = 5'd0;
            ndone = 1'b0;
            nerr  = 1'b0;
        end else begin
            if (calc_en) begin
                // Classic CAN excludes stuff bits from CRC-15; FD CRCs cover them.
                if (!isStuff)
                    n15 = {crc15[13:0], 1'b0} ^ ((canRX ^ crc15[14]) ? POLY15 : 15'h0);
                n17 = {crc17[15:0], 1'b0} ^ ((canRX ^ crc17[16]) ? POLY17 : 17'h0);
                n21 = {crc21[19:0], 1'b0} ^ ((canRX ^ crc21[20]) ? POLY21 : 21'h0);
            end
            if (chk_en) begin
                nrx = {rxCrc[19:0], canRX};
                if (bitCnt != 5'd31)
                    ncnt = bitCnt + 5'd1;
                if (selReg != 2'd0 && ncnt == width) begin
                    ndone = 1'b1;
                    nerr  = ((nrx & mask) != sel_crc);
                end
            end
        end
    end

    always_comb begin
        nres = 21'h0;
        nbit = 1'b0;
        case (nsel)
            2'd1: begin nres = {6'd0, n15}; nbit = n15[14]; end
            2'd2: begin nres = {4'd0, n17}; nbit = n17[16]; end
            2'd3: begin nres = n21;         nbit = n21[20]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc15     <= 15'h0;
            crc17     <= 17'h0;
            crc21     <= 21'h0;
            selReg    <= 2'd0;
            rxCrc     <= 21'h0;
            bitCnt    <= 5'd0;
            crcDone   <= 1'b0;
            crcError  <= 1'b0;
            crcResult <= 21'h0;
            crcBitOut <= 1'b0;
        end else begin
            crc15     <= n15;
            crc17     <= n17;
            crc21     <= n21;
            selReg    <= nsel;
            rxCrc     <= nrx;
            bitCnt    <= ncnt;
            crcDone   <= ndone;
            crcError  <= nerr;
            crcResult <= nres;
            crcBitOut <= nbit;
        end
    end

endmodule

// File: tb/tb_can_crc_unit.sv
// Directed bench for can_crc_unit with hand-computed CRC values.
module tb_can_crc_unit;

    logic        clk;
    logic        reset_n;
    logic        samplePoint;
    logic        canRX;
    logic        isStuff;
    logic        crcStart;
    logic        crcCalc_on;
    logic        crcCheck;
    logic [1:0]  crcSel;
    logic [20:0] crcResult;
    logic        crcBitOut;
    logic        crcDone;
    logic        crcError;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];

    can_crc_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .samplePoint (samplePoint),
        .canRX       (canRX),
        .isStuff     (isStuff),
        .crcStart    (crcStart),
        .crcCalc_on  (crcCalc_on),
        .crcCheck    (crcCheck),
        .crcSel      (crcSel),
        .crcResult   (crcResult),
        .crcBitOut   (crcBitOut),
        .crcDone     (crcDone),
        .crcError    (crcError)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [20:0] obs);
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty, got 0x%0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, obs, e);
        end
    endtask

    // driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] sel);
        crcStart = 1'b1;
        crcSel   = sel;
        tick();
        crcStart = 1'b0;
        crcSel   = 2'd0;
    endtask

    task automatic sample(input logic b, input logic stuff, input logic calc, input logic chk);
        samplePoint = 1'b1;
        canRX       = b;
        isStuff     = stuff;
        crcCalc_on  = calc;
        crcCheck    = chk;
        tick();
        samplePoint = 1'b0;
        canRX       = 1'b0;
        isStuff     = 1'b0;
        crcCalc_on  = 1'b0;
        crcCheck    = 1'b0;
    endtask

    // Shift the first nbits of a w-bit field MSB-first; a stuff-flagged bit goes in before index stuff_pos.
    task automatic shift_field(input logic [20:0] val, input int w, input int stuff_pos,
                               input int nbits, input logic calc);
        for (int k = 0; k < nbits; k++) begin
            if (k == stuff_pos)
                sample(~val[w-1-k], 1'b1, calc, 1'b1);
            sample(val[w-1-k], 1'b0, calc, 1'b1);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        samplePoint = 1'b0;
        canRX       = 1'b0;
        isStuff     = 1'b0;
        crcStart    = 1'b0;
        crcCalc_on  = 1'b0;
        crcCheck    = 1'b0;
        crcSel      = 2'd0;
        tick();
        tick();
        check_eq("reset_result", crcResult, 21'h0);
        check_eq("reset_bitout", {20'h0, crcBitOut}, 21'h0);
        check_eq("reset_done",   {20'h0, crcDone}, 21'h0);
        check_eq("reset_error",  {20'h0, crcError}, 21'h0);
        reset_n = 1'b1;
        tick();

        // single bit into CRC-15
        start(2'd1);
        sample(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        exp_q.push_back(21'h4599);
        check_q("crc15_one_bit", crcResult);
        check_eq("crc15_bitout", {20'h0, crcBitOut}, 21'h1);
        check_eq("crc15_not_done", {20'h0, crcDone}, 21'h0);

        // CRC-17 from its start value
        start(2'd2);
        tick();
        exp_q.push_back(21'h10000);
        check_q("crc17_init", crcResult);
        sample(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        exp_q.push_back(21'h00000);
        check_q("crc17_bit1", crcResult);
        check_eq("crc17_bit1_bitout", {20'h0, crcBitOut}, 21'h0);
        start(2'd2);
        sample(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exp_q.push_back(21'h1685B);
        check_q("crc17_bit0", crcResult);
        check_eq("crc17_bit0_bitout", {20'h0, crcBitOut}, 21'h1);

        // stuff bits: skipped by CRC-15, included by CRC-21
        start(2'd1);
        sample(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        exp_q.push_back(21'h0000);
        check_q("crc15_stuff_skip", crcResult);
        start(2'd3);
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        exp_q.push_back(21'h102899);
        check_q("crc21_stuff_incl", crcResult);
        check_eq("crc21_bitout", {20'h0, crcBitOut}, 21'h1);

        // samplePoint with neither phase enabled changes nothing
        sample(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("idle_sample", crcResult, 21'h102899);

        // CRC-15 check pass, stuff bit mid-field
        start(2'd1);
        sample(1'b1, 1'b0, 1'b1, 1'b0);
        shift_field(21'h4599, 15, 7, 14, 1'b0);
        tick();
        check_eq("pass_done_early", {20'h0, crcDone}, 21'h0);
        sample(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("pass_done",   {20'h0, crcDone}, 21'h1);
        check_eq("pass_error",  {20'h0, crcError}, 21'h0);
        check_eq("pass_frozen", crcResult, 21'h4599);
        sample(1'b0, 1'b0, 1'b0, 1'b1);
        sample(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("post_done_hold",  {20'h0, crcDone}, 21'h1);
        check_eq("post_done_error", {20'h0, crcError}, 21'h0);

        // CRC-15 check fail, last bit flipped
        start(2'd1);
        check_eq("start_clears_done", {20'h0, crcDone}, 21'h0);
        sample(1'b1, 1'b0, 1'b1, 1'b0);
        shift_field(21'h4599, 15, 7, 14, 1'b0);
        sample(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("fail_done",  {20'h0, crcDone}, 21'h1);
        check_eq("fail_error", {20'h0, crcError}, 21'h1);

        // CRC-21 check pass over its full width
        start(2'd3);
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        shift_field(21'h102899, 21, 10, 21, 1'b0);
        tick();
        check_eq("crc21_done",  {20'h0, crcDone}, 21'h1);
        check_eq("crc21_error", {20'h0, crcError}, 21'h0);

        // crcStart beats a coincident sample
        crcStart    = 1'b1;
        crcSel      = 2'd1;
        samplePoint = 1'b1;
        canRX       = 1'b1;
        crcCalc_on  = 1'b1;
        tick();
        crcStart    = 1'b0;
        crcSel      = 2'd0;
        samplePoint = 1'b0;
        canRX       = 1'b0;
        crcCalc_on  = 1'b0;
        tick();
        check_eq("start_priority", crcResult, 21'h0000);

        // crcCheck beats crcCalc_on: CRC frozen while bits are counted
        sample(1'b1, 1'b0, 1'b1, 1'b0);
        shift_field(21'h4599, 15, 99, 15, 1'b1);
        tick();
        check_eq("both_frozen", crcResult, 21'h4599);
        check_eq("both_done",   {20'h0, crcDone}, 21'h1);
        check_eq("both_error",  {20'h0, crcError}, 21'h0);

        // asynchronous reset mid-frame, away from any clock edge
        start(2'd1);
        sample(1'b1, 1'b0, 1'b1, 1'b0);
        shift_field(21'h4599, 15, 99, 5, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_result", crcResult, 21'h0);
        check_eq("async_bitout", {20'h0, crcBitOut}, 21'h0);
        check_eq("async_done",   {20'h0, crcDone}, 21'h0);
        check_eq("async_error",  {20'h0, crcError}, 21'h0);
        #1;
        reset_n = 1'b1;
        tick();
        shift_field(21'h0, 21, 99, 21, 1'b0);
        tick();
        check_eq("nosel_done",   {20'h0, crcDone}, 21'h0);
        check_eq("nosel_error",  {20'h0, crcError}, 21'h0);
        check_eq("nosel_result", crcResult, 21'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
